// File: rtl/common.sv
// Shared types and default parameters for the branch-predictor slice.
//   u64        : 64-bit address type used for PCs
//   bp_state_t : predictor FSM states (table sweep, normal operation)
package common;

  typedef logic [63:0] u64;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } bp_state_t;

  localparam int unsigned DEF_INDEX_BITS = 10;
  localparam int unsigned DEF_CTR_BITS   = 2;
  localparam int unsigned DEF_GHR_BITS   = 8;
  localparam int unsigned DEF_PC_SHIFT   = 2;

endpackage

// File: rtl/sat_ctr_update.sv
// Combinational next value of a saturating up/down counter.
//   ctr      : current counter value
//   taken    : 1 = count up, 0 = count down
//   ctr_next : updated value, clamped at all-ones and zero
module sat_ctr_update #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != '1) ctr_next = ctr + CTR_BITS'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor.
//   clk, rst_n        : clock, synchronous active-low reset
//   ready             : table initialised, predictions valid
//   pred_valid/pc     : prediction consumed this cycle / PC to predict
//   pred_taken/ghr    : combinational prediction, history used for it
//   fb_valid/pc/ghr   : resolved branch, its PC and the history snapshot it was predicted with
//   fb_taken          : actual outcome
//   fb_mispredict     : predicted direction was wrong (repairs history)
//   mispredict_count  : saturating count of accepted mispredicts
// After reset the table is swept to weakly-taken, one entry per cycle.
module gshare_predictor
  import common::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned CTR_BITS   = DEF_CTR_BITS,
  parameter int unsigned GHR_BITS   = DEF_GHR_BITS,
  parameter int unsigned PC_SHIFT   = DEF_PC_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic                pred_valid,
  input  u64                  pred_pc,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                fb_valid,
  input  u64                  fb_pc,
  input  logic [GHR_BITS-1:0] fb_ghr,
  input  logic                fb_taken,
  input  logic                fb_mispredict,
  output logic [31:0]         mispredict_count
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] WeakTaken = CTR_BITS'(1 << (CTR_BITS - 1));

  typedef logic [INDEX_BITS-1:0] idx_t;

  function automatic idx_t calc_idx(input u64 pc, input logic [GHR_BITS-1:0] g);
    return pc[INDEX_BITS+PC_SHIFT-1:PC_SHIFT] ^ idx_t'(g);
  endfunction

  bp_state_t           state_q;
  idx_t                sweep_q;
  logic [GHR_BITS-1:0] ghr_q;
  logic [31:0]         mis_q;
  logic [CTR_BITS-1:0] table_q [Entries];

  idx_t                pred_idx, fb_idx, wr_addr;
  logic [CTR_BITS-1:0] ctr_next, wr_data;
  logic                wr_en;
  logic                fb_acc, repair, spec;
  logic [GHR_BITS-1:0] ghr_spec, ghr_fix;

  assign ready            = (state_q == RUN);
  assign pred_idx         = calc_idx(pred_pc, ghr_q);
  assign fb_idx           = calc_idx(fb_pc, fb_ghr);
  assign pred_taken       = ready & table_q[pred_idx][CTR_BITS-1];
  assign pred_ghr         = ghr_q;
  assign mispredict_count = mis_q;

  assign fb_acc = fb_valid & ready;
  assign repair = fb_acc & fb_mispredict;
  assign spec   = pred_valid & ready;

  // A one-bit history has no older bits to keep.
  if (GHR_BITS == 1) begin : g_ghr1
    assign ghr_spec = pred_taken;
    assign ghr_fix  = fb_taken;
  end else begin : g_ghrn
    assign ghr_spec = {ghr_q[GHR_BITS-2:0], pred_taken};
    assign ghr_fix  = {fb_ghr[GHR_BITS-2:0], fb_taken};
  end

  sat_ctr_update #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_ctr_update (
    .ctr      (table_q[fb_idx]),
    .taken    (fb_taken),
    .ctr_next (ctr_next)
  );

  // Single write port: sweep owns it in INIT, feedback in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep_q;
    wr_data = WeakTaken;
    if (state_q == INIT) begin
      wr_en = 1'b1;
    end else if (fb_acc) begin
      wr_en   = 1'b1;
      wr_addr = fb_idx;
      wr_data = ctr_next;
    end
  end

  // No reset on the array so it can map onto RAM; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) table_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
      mis_q   <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          sweep_q <= sweep_q + idx_t'(1);
          if (sweep_q == '1) state_q <= RUN;
        end
        RUN: begin
          // Repair discards any same-cycle speculative shift.
          if (repair) ghr_q <= ghr_fix;
          else if (spec) ghr_q <= ghr_spec;
          if (repair && (mis_q != '1)) mis_q <= mis_q + 32'd1;
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule
